// File: rtl/mdu_ctrl_if.sv
// Signal bundle between the E-stage issue logic and the multiply/divide unit.
// The slave modport is the unit's view; master is the issue/hazard side.
interface mdu_ctrl_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        md_use_d;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;
  logic        md_stall;

  modport slave (
    input  start, op, A, B, md_use_d,
    output busy, HI, LO, md_stall
  );

  modport master (
    output start, op, A, B, md_use_d,
    input  busy, HI, LO, md_stall
  );
endinterface

// File: rtl/mdu_ctrl.sv
// Multi-cycle MIPS-style multiply/divide controller with HI/LO registers.
// Results are computed from latched operands and committed when the busy window ends.
module mdu_ctrl #(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input  logic       clk,
  input  logic       reset,
  mdu_ctrl_if.slave  md
);

  typedef enum logic {IDLE, RUN} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [1:0]  op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic signed [63:0] a_ext, b_ext, mul_s;
  logic        [63:0] mul_u;

  // Returns {remainder, quotient}; the one overflowing case is pinned explicitly.
  function automatic logic [63:0] div_signed(input logic signed [31:0] n,
                                             input logic signed [31:0] d);
    if (n == 32'sh8000_0000 && d == -32'sd1) return {32'h0, 32'h8000_0000};
    return {32'(n % d), 32'(n / d)};
  endfunction

  function automatic logic [63:0] div_unsigned(input logic [31:0] n,
                                               input logic [31:0] d);
    return {n % d, n / d};
  endfunction

  assign a_ext = $signed({{32{a_q[31]}}, a_q});
  assign b_ext = $signed({{32{b_q[31]}}, b_q});
  assign mul_s = a_ext * b_ext;
  assign mul_u = {32'h0, a_q} * {32'h0, b_q};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      IDLE: begin
        if (md.start) begin
          unique case (md.op)
            3'd0, 3'd1, 3'd2, 3'd3: begin
              op_d    = md.op[1:0];
              a_d     = md.A;
              b_d     = md.B;
              cnt_d   = md.op[1] ? 4'(DIV_CYC) : 4'(MULT_CYC);
              state_d = RUN;
            end
            3'd4:    hi_d = md.A;
            3'd5:    lo_d = md.A;
            default: ;
          endcase
        end
      end
      RUN: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = IDLE;
          // A zero divisor burns the full latency but leaves HI/LO untouched.
          unique case (op_q)
            2'd0: {hi_d, lo_d} = mul_s;
            2'd1: {hi_d, lo_d} = mul_u;
            2'd2: if (b_q != 32'h0) {hi_d, lo_d} = div_signed(a_q, b_q);
            2'd3: if (b_q != 32'h0) {hi_d, lo_d} = div_unsigned(a_q, b_q);
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      hi_q    <= 32'h0;
      lo_q    <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  always_ff @(posedge clk) begin
    op_q <= op_d;
    a_q  <= a_d;
    b_q  <= b_d;
  end

  assign md.busy     = (state_q == RUN);
  assign md.HI       = hi_q;
  assign md.LO       = lo_q;
  assign md.md_stall = md.md_use_d & (md.start | md.busy);

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed self-checking bench for mdu_ctrl: arithmetic results, busy timing,
// hazard stall, MTHI/MTLO, no-op and reset behaviour.
module tb_mdu_ctrl;

  logic clk;
  logic reset;
  int   n_total;
  int   n_pass;

  mdu_ctrl_if bus();

  mdu_ctrl #(.MULT_CYC(5), .DIV_CYC(10)) dut (
    .clk   (clk),
    .reset (reset),
    .md    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, time=%0t required=finish", $time);
    $fatal(1, "watchdog expired");
  end

  // Issues one start at a negedge, then counts busy cycles (bounded). Returns at
  // the negedge where busy has fallen; early flags any HI/LO change while busy.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int cyc, output logic early);
    logic [31:0] h0, l0;
    @(negedge clk);
    h0 = bus.HI; l0 = bus.LO;
    bus.start = 1'b1; bus.op = o; bus.A = a; bus.B = b;
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 0; early = 1'b0;
    while (bus.busy === 1'b1 && cyc < 40) begin
      if (bus.HI !== h0 || bus.LO !== l0) early = 1'b1;
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; bus.md_use_d = 1'b1;
    @(negedge clk); @(negedge clk);
    n_total++; if (bus.HI !== 32'h0) $display("FAIL reset_hi: got %h want %h", bus.HI, 32'h0); else n_pass++;
    n_total++; if (bus.LO !== 32'h0) $display("FAIL reset_lo: got %h want %h", bus.LO, 32'h0); else n_pass++;
    n_total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy); else n_pass++;
    n_total++; if (bus.md_stall !== 1'b0) $display("FAIL reset_stall: got %b want 0", bus.md_stall); else n_pass++;
    reset = 1'b0; bus.md_use_d = 1'b0;
  endtask

  task automatic test_mult();
    int cyc; logic early;
    run_op(3'd0, 32'hFFFF_FFFF, 32'h2, cyc, early);
    n_total++; if (cyc != 5) $display("FAIL mult_busy_cycles: got %0d want 5", cyc); else n_pass++;
    n_total++; if (early !== 1'b0) $display("FAIL mult_early_update: got %b want 0", early); else n_pass++;
    n_total++; if (bus.HI !== 32'hFFFF_FFFF) $display("FAIL mult_hi: got %h want ffffffff", bus.HI); else n_pass++;
    n_total++; if (bus.LO !== 32'hFFFF_FFFE) $display("FAIL mult_lo: got %h want fffffffe", bus.LO); else n_pass++;
    run_op(3'd1, 32'hFFFF_FFFF, 32'h2, cyc, early);
    n_total++; if (cyc != 5) $display("FAIL multu_busy_cycles: got %0d want 5", cyc); else n_pass++;
    n_total++; if (bus.HI !== 32'h0000_0001) $display("FAIL multu_hi: got %h want 00000001", bus.HI); else n_pass++;
    n_total++; if (bus.LO !== 32'hFFFF_FFFE) $display("FAIL multu_lo: got %h want fffffffe", bus.LO); else n_pass++;
  endtask

  task automatic test_div();
    int cyc; logic early;
    run_op(3'd2, 32'hFFFF_FFF9, 32'h2, cyc, early);
    n_total++; if (cyc != 10) $display("FAIL div_busy_cycles: got %0d want 10", cyc); else n_pass++;
    n_total++; if (early !== 1'b0) $display("FAIL div_early_update: got %b want 0", early); else n_pass++;
    n_total++; if (bus.LO !== 32'hFFFF_FFFD) $display("FAIL div_lo: got %h want fffffffd", bus.LO); else n_pass++;
    n_total++; if (bus.HI !== 32'hFFFF_FFFF) $display("FAIL div_hi: got %h want ffffffff", bus.HI); else n_pass++;
    run_op(3'd3, 32'h7, 32'h0, cyc, early);
    n_total++; if (cyc != 10) $display("FAIL divu0_busy_cycles: got %0d want 10", cyc); else n_pass++;
    n_total++; if (bus.HI !== 32'hFFFF_FFFF) $display("FAIL divu0_hi: got %h want ffffffff", bus.HI); else n_pass++;
    n_total++; if (bus.LO !== 32'hFFFF_FFFD) $display("FAIL divu0_lo: got %h want fffffffd", bus.LO); else n_pass++;
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, cyc, early);
    n_total++; if (bus.LO !== 32'h8000_0000) $display("FAIL div_ovf_lo: got %h want 80000000", bus.LO); else n_pass++;
    n_total++; if (bus.HI !== 32'h0) $display("FAIL div_ovf_hi: got %h want 00000000", bus.HI); else n_pass++;
    run_op(3'd3, 32'd100, 32'd7, cyc, early);
    n_total++; if (bus.LO !== 32'd14) $display("FAIL divu_lo: got %h want 0000000e", bus.LO); else n_pass++;
    n_total++; if (bus.HI !== 32'd2) $display("FAIL divu_hi: got %h want 00000002", bus.HI); else n_pass++;
  endtask

  task automatic test_hazard();
    int stall_cnt;
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'd0; bus.A = 32'd3; bus.B = 32'd4; bus.md_use_d = 1'b1;
    #1;
    stall_cnt = (bus.md_stall === 1'b1) ? 1 : 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) bus.start = 1'b0;
      if (k == 2) begin bus.start = 1'b1; bus.op = 3'd0; bus.A = 32'd100; bus.B = 32'd100; end
      if (k == 3) bus.start = 1'b0;
      #1;
      if (bus.md_stall === 1'b1) stall_cnt++;
      else break;
    end
    n_total++; if (stall_cnt != 6) $display("FAIL hazard_stall_cycles: got %0d want 6", stall_cnt); else n_pass++;
    n_total++; if (bus.HI !== 32'h0) $display("FAIL hazard_hi: got %h want 00000000", bus.HI); else n_pass++;
    n_total++; if (bus.LO !== 32'd12) $display("FAIL hazard_lo: got %h want 0000000c", bus.LO); else n_pass++;
    bus.md_use_d = 1'b0;
    @(negedge clk);
    n_total++; if (bus.busy !== 1'b0) $display("FAIL hazard_second_ignored: busy got %b want 0", bus.busy); else n_pass++;
  endtask

  task automatic test_move();
    int cyc; logic early;
    run_op(3'd5, 32'h1234_5678, 32'h0, cyc, early);
    n_total++; if (bus.LO !== 32'h1234_5678) $display("FAIL mtlo_lo: got %h want 12345678", bus.LO); else n_pass++;
    n_total++; if (cyc != 0) $display("FAIL mtlo_busy_cycles: got %0d want 0", cyc); else n_pass++;
    n_total++; if (bus.HI !== 32'h0) $display("FAIL mtlo_hi_kept: got %h want 00000000", bus.HI); else n_pass++;
    run_op(3'd4, 32'hCAFE_F00D, 32'h0, cyc, early);
    n_total++; if (bus.HI !== 32'hCAFE_F00D) $display("FAIL mthi_hi: got %h want cafef00d", bus.HI); else n_pass++;
    n_total++; if (bus.LO !== 32'h1234_5678) $display("FAIL mthi_lo_kept: got %h want 12345678", bus.LO); else n_pass++;
  endtask

  task automatic test_noop();
    int cyc; logic early;
    run_op(3'd6, 32'hDEAD_BEEF, 32'h5, cyc, early);
    n_total++; if (cyc != 0) $display("FAIL noop6_busy: got %0d want 0", cyc); else n_pass++;
    run_op(3'd7, 32'hDEAD_BEEF, 32'h5, cyc, early);
    n_total++; if (cyc != 0) $display("FAIL noop7_busy: got %0d want 0", cyc); else n_pass++;
    n_total++; if (bus.HI !== 32'hCAFE_F00D) $display("FAIL noop_hi: got %h want cafef00d", bus.HI); else n_pass++;
    n_total++; if (bus.LO !== 32'h1234_5678) $display("FAIL noop_lo: got %h want 12345678", bus.LO); else n_pass++;
  endtask

  task automatic test_reset_mid_div();
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'd2; bus.A = 32'd100; bus.B = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    n_total++; if (bus.busy !== 1'b1) $display("FAIL rstdiv_busy_started: got %b want 1", bus.busy); else n_pass++;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_total++; if (bus.busy !== 1'b0) $display("FAIL rstdiv_busy: got %b want 0", bus.busy); else n_pass++;
    n_total++; if (bus.HI !== 32'h0) $display("FAIL rstdiv_hi: got %h want 00000000", bus.HI); else n_pass++;
    n_total++; if (bus.LO !== 32'h0) $display("FAIL rstdiv_lo: got %h want 00000000", bus.LO); else n_pass++;
    repeat (12) @(negedge clk);
    n_total++; if (bus.HI !== 32'h0 || bus.LO !== 32'h0)
      $display("FAIL rstdiv_no_late_update: got %h_%h want 00000000_00000000", bus.HI, bus.LO); else n_pass++;
  endtask

  task automatic test_reset_priority();
    @(negedge clk);
    reset = 1'b1; bus.start = 1'b1; bus.op = 3'd0; bus.A = 32'd3; bus.B = 32'd3;
    @(negedge clk);
    reset = 1'b0; bus.start = 1'b0;
    n_total++; if (bus.busy !== 1'b0) $display("FAIL rstprio_busy: got %b want 0", bus.busy); else n_pass++;
    @(negedge clk);
    reset = 1'b1; bus.start = 1'b1; bus.op = 3'd5; bus.A = 32'h55;
    @(negedge clk);
    reset = 1'b0; bus.start = 1'b0;
    n_total++; if (bus.LO !== 32'h0) $display("FAIL rstprio_mtlo: got %h want 00000000", bus.LO); else n_pass++;
    @(negedge clk);
    n_total++; if (bus.busy !== 1'b0) $display("FAIL rstprio_busy_after: got %b want 0", bus.busy); else n_pass++;
  endtask

  initial begin
    n_total = 0; n_pass = 0;
    reset = 1'b1;
    bus.start = 1'b0; bus.op = 3'd0; bus.A = 32'h0; bus.B = 32'h0; bus.md_use_d = 1'b0;
    test_reset();
    test_mult();
    test_div();
    test_hazard();
    test_move();
    test_noop();
    test_reset_mid_div();
    test_reset_priority();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
